pc_gen: RTL and testbench

PC_GEN -- requirements
Module: pc_gen

---
 rtl/pc_gen.sv | 74 +++++++
 tb/tb_pc_gen.sv | 132 +++++++++++++
 2 files changed

// File: rtl/pc_gen.sv
// pc_gen: fetch PC generator with trap/branch/return redirects and a circular return-address stack.
module pc_gen #(
  parameter int                ADDR_W    = 32,
  parameter logic [ADDR_W-1:0] RESET_VEC = '0,
  parameter logic [ADDR_W-1:0] TRAP_VEC  = ADDR_W'('h100),
  parameter int                STEP      = 4,
  parameter int                RAS_DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall,
  input  logic              trap,
  input  logic              branch_en,
  input  logic [ADDR_W-1:0] branch,
  input  logic              call,
  input  logic              ret,
  output logic              ce,
  output logic [ADDR_W-1:0] pc,
  output logic [ADDR_W-1:0] pc_plus_step,
  output logic              ras_empty,
  output logic              ras_full,
  output logic              misalign
);
  localparam int PW = $clog2(RAS_DEPTH);
  localparam logic [ADDR_W-1:0] LOW = ADDR_W'(STEP - 1);
  logic [ADDR_W-1:0] pc_q, pc_d, top;
  logic              ce_q, mis_q, mis_d, act, push, pop;
  logic [PW-1:0]     sp_q, sp_d, top_idx, wr_idx;
  logic [PW:0]       cnt_q, cnt_d;
  logic [ADDR_W-1:0] ras_q [RAS_DEPTH];
  assign ce           = ce_q;
  assign pc           = pc_q;
  assign misalign     = mis_q;
  assign pc_plus_step = pc_q + ADDR_W'(STEP);
  assign ras_empty    = cnt_q == '0;
  assign ras_full     = cnt_q == (PW + 1)'(RAS_DEPTH);
  // sp_q is the next free slot; when full it points at the oldest entry, so a push overwrites it
  always_comb begin
    act     = ce_q & ~trap & ~stall;
    push    = act & call;
    pop     = act & ret & ~branch_en & ~ras_empty;
    top_idx = sp_q - PW'(1);
    top     = ras_q[top_idx];
    wr_idx  = pop ? top_idx : sp_q;
    pc_d    = !ce_q     ? pc_q :
              trap      ? TRAP_VEC :
              branch_en ? (branch & ~LOW) :
              pop       ? top :
              stall     ? pc_q : pc_plus_step;
    mis_d   = ce_q & ~trap & branch_en & |(branch & LOW);
    sp_d    = (push & ~pop) ? sp_q + PW'(1) : (pop & ~push) ? top_idx : sp_q;
    cnt_d   = trap                      ? '0 :
              (push & ~pop & ~ras_full) ? cnt_q + (PW + 1)'(1) :
              (pop & ~push)             ? cnt_q - (PW + 1)'(1) : cnt_q;
  end
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q  <= RESET_VEC;
      ce_q  <= 1'b0;
      mis_q <= 1'b0;
      sp_q  <= '0;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      ce_q  <= 1'b1;
      mis_q <= mis_d;
      sp_q  <= sp_d;
      cnt_q <= cnt_d;
    end
  end
  always_ff @(posedge clk) begin
    if (push) ras_q[wr_idx] <= pc_plus_step;
  end
endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vectors into a scoreboard queue, checked by an independent monitor.
module tb_pc_gen;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stall = 1'b0, trap = 1'b0, branch_en = 1'b0, call = 1'b0, ret = 1'b0;
  logic [31:0] branch = '0;
  logic        ce, ras_empty, ras_full, misalign;
  logic [31:0] pc, pc_plus_step;
  int          checks = 0;
  int          errors = 0;
  typedef struct {
    logic [31:0] pc;
    logic        ce, mis, emp, full;
    string       nm;
  } exp_t;
  exp_t q[$];
  event smp;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .trap(trap), .branch_en(branch_en),
    .branch(branch), .call(call), .ret(ret), .ce(ce), .pc(pc),
    .pc_plus_step(pc_plus_step), .ras_empty(ras_empty), .ras_full(ras_full),
    .misalign(misalign)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    #1;
    -> smp;
  end

  initial begin
    exp_t e;
    forever begin
      @(smp);
      if (q.size() > 0) begin
        e = q.pop_front();
        checks++;
        if ({pc, pc_plus_step, ce, misalign, ras_empty, ras_full} !==
            {e.pc, e.pc + 32'd4, e.ce, e.mis, e.emp, e.full}) begin
          errors++;
          $display("FAIL %s: got pc=%h pps=%h ce=%b mis=%b emp=%b full=%b, want pc=%h pps=%h ce=%b mis=%b emp=%b full=%b",
                   e.nm, pc, pc_plus_step, ce, misalign, ras_empty, ras_full,
                   e.pc, e.pc + 32'd4, e.ce, e.mis, e.emp, e.full);
        end
      end
    end
  end

  task automatic expect_st(input logic [31:0] epc, input logic ece, emis, eemp, efull, input string nm);
    exp_t e;
    e.pc = epc; e.ce = ece; e.mis = emis; e.emp = eemp; e.full = efull; e.nm = nm;
    q.push_back(e);
  endtask

  // Drive one cycle's inputs at the falling edge and queue the state expected after the next rising edge
  task automatic cyc(input logic st, tr, be, input logic [31:0] br, input logic cl, rt,
                     input logic [31:0] epc, input logic emis, eemp, efull, input string nm);
    @(negedge clk);
    stall = st; trap = tr; branch_en = be; branch = br; call = cl; ret = rt;
    expect_st(epc, 1'b1, emis, eemp, efull, nm);
  endtask

  initial begin
    @(negedge clk);
    expect_st(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_state");
    @(negedge clk);
    rst = 1'b1;
    expect_st(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "ce_rise_pc_held");
    cyc(0,0,0,0,         0,0, 32'h4,   0,1,0, "seq_4");
    cyc(0,0,0,0,         0,0, 32'h8,   0,1,0, "seq_8");
    cyc(1,0,1,32'h203,   0,0, 32'h200, 1,1,0, "branch_misalign_stall");
    cyc(0,0,0,0,         0,0, 32'h204, 0,1,0, "misalign_one_cycle");
    cyc(1,0,0,0,         0,0, 32'h204, 0,1,0, "stall_hold");
    cyc(1,0,0,0,         1,0, 32'h204, 0,1,0, "stall_ignores_call");
    cyc(0,0,1,32'h10,    0,0, 32'h10,  0,1,0, "branch_aligned");
    cyc(0,0,1,32'h80,    1,0, 32'h80,  0,0,0, "call_with_branch");
    cyc(0,0,0,0,         0,0, 32'h84,  0,0,0, "seq_84");
    cyc(0,0,0,0,         0,0, 32'h88,  0,0,0, "seq_88");
    cyc(0,0,0,0,         0,1, 32'h14,  0,1,0, "ret_to_14");
    cyc(0,0,0,0,         0,1, 32'h18,  0,1,0, "ret_empty_seq");
    cyc(0,0,1,32'h0,     0,0, 32'h0,   0,1,0, "branch_zero");
    cyc(0,0,0,0,         1,0, 32'h4,   0,0,0, "call1");
    cyc(0,0,0,0,         1,0, 32'h8,   0,0,0, "call2");
    cyc(0,0,0,0,         1,0, 32'hC,   0,0,0, "call3");
    cyc(0,0,0,0,         1,0, 32'h10,  0,0,1, "call4_full");
    cyc(0,0,0,0,         1,0, 32'h14,  0,0,1, "call5_overwrite");
    cyc(0,0,0,0,         0,1, 32'h14,  0,0,0, "ret1");
    cyc(0,0,0,0,         0,1, 32'h10,  0,0,0, "ret2");
    cyc(0,0,0,0,         0,1, 32'hC,   0,0,0, "ret3");
    cyc(0,0,0,0,         0,1, 32'h8,   0,1,0, "ret4_empty");
    cyc(0,0,0,0,         0,1, 32'hC,   0,1,0, "ret5_seq");
    cyc(0,0,0,0,         1,0, 32'h10,  0,0,0, "push_10");
    cyc(0,0,0,0,         1,1, 32'h10,  0,0,0, "call_ret_replace");
    cyc(0,0,0,0,         0,1, 32'h14,  0,1,0, "ret_replaced_top");
    cyc(0,0,0,0,         1,1, 32'h18,  0,0,0, "call_ret_empty_push");
    cyc(0,0,0,0,         0,1, 32'h18,  0,1,0, "ret_pushed_18");
    cyc(0,0,0,0,         1,0, 32'h1C,  0,0,0, "push_1c");
    cyc(0,0,0,0,         1,0, 32'h20,  0,0,0, "push_20");
    cyc(0,1,1,32'h203,   1,0, 32'h100, 0,1,0, "trap_over_branch");
    cyc(0,0,0,0,         0,1, 32'h104, 0,1,0, "ret_after_trap");
    cyc(1,1,0,0,         0,0, 32'h100, 0,1,0, "trap_over_stall");
    cyc(0,0,1,32'hFFFFFFFE, 0,0, 32'hFFFFFFFC, 1,1,0, "branch_max");
    cyc(0,0,0,0,         0,0, 32'h0,   0,1,0, "wrap_zero");
    cyc(0,0,0,0,         1,0, 32'h4,   0,0,0, "push_4");
    cyc(0,0,1,32'h40,    0,1, 32'h40,  0,0,0, "branch_over_ret");
    cyc(0,0,0,0,         0,1, 32'h4,   0,1,0, "ret_kept_entry");
    cyc(0,0,0,0,         1,0, 32'h8,   0,0,0, "push_8");
    @(negedge clk);
    trap = 1'b1; call = 1'b1; branch_en = 1'b1; branch = 32'h203; rst = 1'b0;
    #1;
    expect_st(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "async_reset");
    -> smp;
    @(negedge clk);
    expect_st(32'h0, 1'b0, 1'b0, 1'b1, 1'b0, "reset_held");
    @(negedge clk);
    rst = 1'b1;
    expect_st(32'h0, 1'b1, 1'b0, 1'b1, 1'b0, "rerelease_ce");
    cyc(0,0,0,0,         0,1, 32'h4,   0,1,0, "ras_cleared_by_reset");
    @(negedge clk);
    stall = 1'b0; trap = 1'b0; branch_en = 1'b0; call = 1'b0; ret = 1'b0;
    @(negedge clk);
    checks++;
    if (q.size() != 0) begin
      errors++;
      $display("FAIL queue_drain: %0d entries left, want 0", q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
